datapath_ctrl: RTL and testbench
================================

// Module: datapath_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 16-bit datapath (regfile + shifter + ALU + A/B/C/status regs).
//  Accepts one register-level command per valid/ready handshake; drives all datapath control
//  lines state by state; pulses done on the final cycle. Sits between the instruction source
//  (testbench or future decoder) and the datapath; one command in flight at a time.
// PARAMETERS
//  DW     16  datapath word width (width of dp_in)
//  RAW    3   register address width (8 registers)
//  IMM_W  8   immediate width; sign-extended to DW for MOVI
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      high only in S_IDLE
//  cmd_op     in   3      000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 11x illegal
//  cmd_rd     in   RAW    destination register
//  cmd_rn     in   RAW    first source (ADD/CMP/AND)
//  cmd_rm     in   RAW    shifted source (MOV/ADD/CMP/AND/MVN)
//  cmd_sh     in   2      shift_op applied to Rm
//  cmd_imm    in   IMM_W  immediate for MOVI
//  done       out  1      one-cycle pulse in the command's last state
//  err        out  1      with done: command was illegal, nothing written
//  dp_in      out  DW     sign-extended latched immediate (datapath_in)
//  wb_sel w_en en_A en_B sel_A sel_B en_C en_status  out 1 each; w_addr r_addr out RAW;
//  shift_op ALU_op out 2  -- connect 1:1 to the datapath
// BEHAVIOUR
//  - Fields latched on cmd_valid&&cmd_ready; inputs ignored while busy.
//  - Moore outputs from state + latched fields; default all enables 0, sel_B=0, wb_sel=0.
//  - ALU_op: 00 ADD, 01 SUB, 10 AND, 11 NOT B. Regfile read is combinational; r_addr and the
//    A/B enable are driven in the same state.
//  - States: S_IDLE, S_WIMM, S_LDA, S_LDB, S_EXEC, S_WB, S_ERR.
//    MOVI:    IDLE>WIMM(wb_sel=1,w_en,w_addr=rd; done)>IDLE              latency 1
//    MOV:     IDLE>LDB(r_addr=rm,en_B)>EXEC(sel_A=1,ADD,en_C)>WB>IDLE     latency 3
//    MVN:     IDLE>LDB>EXEC(NOT,en_C)>WB>IDLE                             latency 3
//    ADD/AND: IDLE>LDA(r_addr=rn,en_A)>LDB>EXEC(en_C)>WB>IDLE             latency 4
//    CMP:     IDLE>LDA>LDB>EXEC(SUB,en_status,en_C=0; done)>IDLE          latency 3
//    WB:      wb_sel=0,w_en=1,w_addr=rd; done. Illegal: IDLE>ERR(done,err)>IDLE, no enables.
//  - shift_op = latched sh in every state (shifter is combinational on B).
//  - Latency = cycles from accept edge to the done cycle. cmd_ready re-asserts the cycle after
//    done, so back-to-back commands have no idle gap beyond that one IDLE cycle.
//  - Only CMP asserts en_status; the Z flag is unchanged by all other ops.
//  - rd == rn or rd == rm is legal: sources are captured in A/B before WB.
//  - Reset (any time, incl. mid-command): state S_IDLE, cmd_ready=1 after release, done=err=0,
//    all enables 0, dp_in=0, latched fields 0. An aborted command produces no further write
//    and no done.
//  - cmd_valid high during reset is not accepted until the first edge after release.
// STRUCTURE
//  - Package dp_ctrl_pkg: state_t enum, op_t enum (cmd_op codes), ALU_ADD/SUB/AND/NOT and
//    SH_* constants, and a function first_state(op_t) returning S_WIMM/S_LDA/S_LDB/S_ERR.
//  - Single module, no sub-modules: one always_ff (state + latched fields, async rst) and one
//    always_comb (next state + outputs).
// TESTING  (bench instantiates datapath_ctrl driving the real datapath)
//  - MOVI rd=0 imm=8'h07; MOVI rd=1 imm=8'hFE -> done 1 cycle after each accept; R0=0x0007,
//    R1=0xFFFE.
//  - ADD rd=2 rn=0 rm=1 sh=01 (LSL) -> done exactly 4 cycles after accept; R2=0x0007+0xFFFC=0x0003.
//  - CMP rn=0 rm=0 sh=00 -> done at 3 cycles, Z_out=1, no w_en seen; next MOV rd=3 rm=1 leaves
//    Z_out=1, R3=0xFFFE.
//  - MVN rd=4 rm=0 -> R4=0xFFF8; AND rd=5 rn=4 rm=1 -> R5=0xFFF8; rd=rn case ADD rd=0 rn=0 rm=0
//    -> R0=0x000E.
//  - Illegal op 3'b110 -> done&&err 1 cycle after accept, no enable asserted, regs unchanged;
//    cmd_valid held high while busy -> exactly one accept per ready cycle.
//  - Assert rst in S_EXEC of an ADD to R6 -> outputs zero asynchronously, R6 unchanged, no done;
//    after release cmd_ready=1 and a new MOVI completes normally.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the datapath sequencer: state/op encodings,
// ALU and shifter op codes, and the entry-state decode for a freshly accepted command.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIMM,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OP_MOVI = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_CMP  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVN  = 3'b101,
    OP_IL6  = 3'b110,
    OP_IL7  = 3'b111
  } op_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Single-source ops skip the A load; MOVI never touches the read port.
  function automatic state_t first_state(input op_t op);
    case (op)
      OP_MOVI:                first_state = S_WIMM;
      OP_ADD, OP_CMP, OP_AND: first_state = S_LDA;
      OP_MOV, OP_MVN:         first_state = S_LDB;
      default:                first_state = S_ERR;
    endcase
  endfunction

endpackage

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the 16-bit regfile/shifter/ALU datapath: accepts one command
// per handshake and drives Moore control lines from state plus latched command fields.
module datapath_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RAW   = 3,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RAW-1:0]   cmd_rd,
  input  logic [RAW-1:0]   cmd_rn,
  input  logic [RAW-1:0]   cmd_rm,
  input  logic [1:0]       cmd_sh,
  input  logic [IMM_W-1:0] cmd_imm,
  output logic             done,
  output logic             err,
  output logic [DW-1:0]    dp_in,
  output logic             wb_sel,
  output logic             w_en,
  output logic             en_A,
  output logic             en_B,
  output logic             sel_A,
  output logic             sel_B,
  output logic             en_C,
  output logic             en_status,
  output logic [RAW-1:0]   w_addr,
  output logic [RAW-1:0]   r_addr,
  output logic [1:0]       shift_op,
  output logic [1:0]       ALU_op
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [RAW-1:0]   rd_q, rd_d;
  logic [RAW-1:0]   rn_q, rn_d;
  logic [RAW-1:0]   rm_q, rm_d;
  logic [1:0]       sh_q, sh_d;
  logic [IMM_W-1:0] imm_q, imm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MOVI;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      sh_q    <= SH_NONE;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      sh_q    <= sh_d;
      imm_q   <= imm_d;
    end
  end

  assign dp_in = {{(DW-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    sh_d      = sh_q;
    imm_d     = imm_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    wb_sel    = 1'b0;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    w_addr    = rd_q;
    r_addr    = rn_q;
    shift_op  = sh_q;
    ALU_op    = ALU_ADD;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = first_state(op_t'(cmd_op));
          op_d    = op_t'(cmd_op);
          rd_d    = cmd_rd;
          rn_d    = cmd_rn;
          rm_d    = cmd_rm;
          sh_d    = cmd_sh;
          imm_d   = cmd_imm;
        end
      end
      S_WIMM: begin
        wb_sel  = 1'b1;
        w_en    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_LDA: begin
        r_addr  = rn_q;
        en_A    = 1'b1;
        state_d = S_LDB;
      end
      S_LDB: begin
        r_addr  = rm_q;
        en_B    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op_q)
          // MOV forces A to zero so ADD passes the shifted B through.
          OP_MOV: begin
            sel_A = 1'b1;
            en_C  = 1'b1;
          end
          OP_MVN: begin
            ALU_op = ALU_NOT;
            en_C   = 1'b1;
          end
          OP_AND: begin
            ALU_op = ALU_AND;
            en_C   = 1'b1;
          end
          OP_CMP: begin
            ALU_op    = ALU_SUB;
            en_status = 1'b1;
            done      = 1'b1;
            state_d   = S_IDLE;
          end
          default: en_C = 1'b1;
        endcase
      end
      S_WB: begin
        w_en    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural datapath is driven by the sequencer, and its
// register file / Z flag are compared against an instruction-level reference model.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [1:0]  cmd_sh;
  logic [7:0]  cmd_imm;
  logic        done, err;
  logic [15:0] dp_in;
  logic        wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status;
  logic [2:0]  w_addr, r_addr;
  logic [1:0]  shift_op, alu_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datapath_ctrl #(.DW(16), .RAW(3), .IMM_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_sh(cmd_sh), .cmd_imm(cmd_imm), .done(done), .err(err), .dp_in(dp_in),
    .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B), .sel_A(sel_A),
    .sel_B(sel_B), .en_C(en_C), .en_status(en_status), .w_addr(w_addr),
    .r_addr(r_addr), .shift_op(shift_op), .ALU_op(alu_op)
  );

  // Behavioural datapath (regfile + shifter + ALU + A/B/C/status)
  logic        dp_clr;
  logic [15:0] rf [8];
  logic [15:0] a_r, b_r, c_r;
  logic        z_out;
  logic [15:0] rd_data, b_sh, ain, bin, alu;

  always_comb begin
    rd_data = rf[r_addr];
    case (shift_op)
      2'd1:    b_sh = {b_r[14:0], 1'b0};
      2'd2:    b_sh = {1'b0, b_r[15:1]};
      2'd3:    b_sh = {b_r[15], b_r[15:1]};
      default: b_sh = b_r;
    endcase
    ain = sel_A ? 16'd0 : a_r;
    bin = sel_B ? {11'd0, dp_in[4:0]} : b_sh;
    case (alu_op)
      2'd0:    alu = ain + bin;
      2'd1:    alu = ain - bin;
      2'd2:    alu = ain & bin;
      default: alu = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
      a_r <= 16'd0; b_r <= 16'd0; c_r <= 16'd0; z_out <= 1'b0;
    end else begin
      if (en_A) a_r <= rd_data;
      if (en_B) b_r <= rd_data;
      if (en_C) c_r <= alu;
      if (en_status) z_out <= (alu == 16'd0);
      if (w_en) rf[w_addr] <= wb_sel ? dp_in : c_r;
    end
  end

  // Instruction-level reference
  logic [15:0] ref_rf [8];
  logic        ref_z;

  function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] sh);
    int s;
    s = $signed(v);
    case (sh)
      2'd1:    return 16'((v * 2) % 65536);
      2'd2:    return v / 16'd2;
      2'd3:    return 16'(s >>> 1);
      default: return v;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op);
    case (op)
      3'd0:       return 1;
      3'd1, 3'd5: return 3;
      3'd2, 3'd4: return 4;
      3'd3:       return 3;
      default:    return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_R%0d", tag, i), {16'd0, rf[i]}, {16'd0, ref_rf[i]});
    chk({tag, "_Z"}, {31'd0, z_out}, {31'd0, ref_z});
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm,
                         input string tag);
    logic [15:0] a, b, val;
    logic        wr, ill, z_new;
    int          w, lat, wen_cnt, st_cnt, en_cnt, sh_bad, err_seen;
    a = ref_rf[rn]; b = ref_shift(ref_rf[rm], sh);
    wr = 1'b1; ill = 1'b0; z_new = ref_z; val = 16'd0;
    case (op)
      3'd0: val = {{8{imm[7]}}, imm};
      3'd1: val = b;
      3'd2: val = a + b;
      3'd3: begin wr = 1'b0; z_new = ((a - b) == 16'd0); end
      3'd4: val = a & b;
      3'd5: val = ~b;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_sh = sh; cmd_imm = imm;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 3'($urandom); cmd_rn = 3'($urandom);
    cmd_rm = 3'($urandom); cmd_sh = 2'($urandom); cmd_imm = 8'($urandom);
    lat = 0; wen_cnt = 0; st_cnt = 0; en_cnt = 0; sh_bad = 0; err_seen = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      if (w_en) wen_cnt++;
      if (en_status) st_cnt++;
      if (en_A | en_B | en_C | en_status | w_en) en_cnt++;
      if (shift_op !== sh) sh_bad++;
      if (done) begin lat = i; err_seen = int'(err); end
      @(posedge clk); #1;
    end
    if (wr) ref_rf[rd] = val;
    ref_z = z_new;
    chk({tag, "_lat"}, lat, ref_latency(op));
    chk({tag, "_err"}, err_seen, {31'd0, ill});
    chk({tag, "_wen"}, wen_cnt, {31'd0, wr});
    chk({tag, "_status"}, st_cnt, (op == 3'd3) ? 32'd1 : 32'd0);
    chk({tag, "_shift"}, sh_bad, 32'd0);
    if (ill) chk({tag, "_noen"}, en_cnt, 32'd0);
    chk({tag, "_idle"}, {31'd0, cmd_ready}, 32'd1);
    chk_regs(tag);
  endtask

  initial begin
    int acc, dn, en;
    rst = 1'b1; dp_clr = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd7; cmd_rn = 3'd0; cmd_rm = 3'd0;
    cmd_sh = 2'd0; cmd_imm = 8'h33;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'd0;
    ref_z = 1'b0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("rst_done", dn, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dp_in", {16'd0, dp_in}, 32'd0);
    chk("rst_en", {27'd0, w_en, en_A, en_B, en_C, en_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0; dp_clr = 1'b0; cmd_valid = 1'b0;

    run_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h07, "movi_r0");
    run_cmd(3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 8'hFE, "movi_r1");
    chk("R0_const", {16'd0, rf[0]}, 32'h0007);
    chk("R1_const", {16'd0, rf[1]}, 32'hFFFE);
    run_cmd(3'd2, 3'd2, 3'd0, 3'd1, 2'd1, 8'h00, "add_lsl");
    chk("R2_const", {16'd0, rf[2]}, 32'h0003);
    run_cmd(3'd3, 3'd7, 3'd0, 3'd0, 2'd0, 8'h00, "cmp_eq");
    chk("Z_const", {31'd0, z_out}, 32'd1);
    run_cmd(3'd1, 3'd3, 3'd0, 3'd1, 2'd0, 8'h00, "mov");
    chk("R3_const", {16'd0, rf[3]}, 32'hFFFE);
    chk("Z_kept", {31'd0, z_out}, 32'd1);
    run_cmd(3'd5, 3'd4, 3'd0, 3'd0, 2'd0, 8'h00, "mvn");
    chk("R4_const", {16'd0, rf[4]}, 32'hFFF8);
    run_cmd(3'd4, 3'd5, 3'd4, 3'd1, 2'd0, 8'h00, "and");
    chk("R5_const", {16'd0, rf[5]}, 32'hFFF8);
    run_cmd(3'd2, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00, "add_self");
    chk("R0_self", {16'd0, rf[0]}, 32'h000E);
    run_cmd(3'd6, 3'd2, 3'd1, 3'd1, 2'd0, 8'h55, "illegal");

    // Illegal op held valid: ERR is one cycle, so ready alternates with busy.
    @(negedge clk);
    cmd_op = 3'd6; cmd_valid = 1'b1;
    acc = 0; dn = 0; en = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) acc++;
      @(posedge clk); #1;
      if (done && err) dn++;
      if (en_A | en_B | en_C | en_status | w_en) en++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("hold_accepts", acc, 32'd5);
    chk("hold_dones", dn, 32'd5);
    chk("hold_noen", en, 32'd0);
    chk_regs("hold");

    // Abort an ADD to R6 while it sits in EXEC.
    @(negedge clk);
    cmd_op = 3'd2; cmd_rd = 3'd6; cmd_rn = 3'd0; cmd_rm = 3'd1; cmd_sh = 2'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_exec", {31'd0, en_C}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_en", {27'd0, w_en, en_A, en_B, en_C, en_status}, 32'd0);
    chk("abort_dp_in", {16'd0, dp_in}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0; en = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (w_en) en++;
    end
    chk("abort_no_done", dn, 32'd0);
    chk("abort_no_wr", en, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk_regs("abort");
    run_cmd(3'd0, 3'd6, 3'd0, 3'd0, 2'd0, 8'h5A, "movi_after_rst");

    for (int k = 0; k < 40; k++)
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
              2'($urandom), 8'($urandom), $sformatf("rnd%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
